conv3x3_layer_strided: RTL and testbench
========================================

// Module: conv3x3_layer_strided
// PURPOSE
//  Parametrised multi-output-channel 3x3 convolution layer; successor to the fixed 16-ch/stride-2 first layer.
//  Consumes one 3x3 window per valid cycle from the line buffer and outputs OCH requantised channel values.
//  Adds true 2-D stride decimation, bias alignment, optional ReLU, saturation, frame tracking and fixed latency.
//  Sits between the line buffer and the pooling / next-layer buffer.
// PARAMETERS
//  F      28  input feature-map width = height (square); valid windows per row/col = F-2
//  B      8   bit width of pixel, weight, bias and output (all two's complement)
//  OCH    16  number of output channels (1..64)
//  STRIDE 2   window stride in both x and y (1 or 2)
//  FRAC   4   fraction bits of weights; bias is pre-shifted left by FRAC, sum shifted right by FRAC
// PORTS
//  i_clk              in   1          clock, rising edge
//  i_rst              in   1          asynchronous reset, active-high
//  i_frame_start      in   1          1-cycle pulse before first window of a frame; latches weights/bias, clears counters
//  i_pixel_data       in   9*B        3x3 window, pixel (r,c) at [(r*3+c)*B +: B], r,c in 0..2
//  i_pixel_data_valid in   1          window valid this cycle
//  i_weight           in   OCH*9*B    channel k tap (r,c) at [(k*9+r*3+c)*B +: B]
//  i_bias             in   OCH*B      channel k bias at [k*B +: B]
//  i_relu_en          in   1          1 = clamp negative results to 0 (sampled per window, travels with pipeline)
//  o_conv_data        out  OCH*B      channel k result at [k*B +: B]
//  o_conv_valid       out  1          o_conv_data valid (one flag for all channels)
//  o_frame_done       out  1          pulses with the last output of a frame
// BEHAVIOUR
//  Reset: o_conv_data=0, o_conv_valid=0, o_frame_done=0, col/row counters=0, latched weights/bias=0, all stage valids=0.
//  Counters: col,row count accepted windows in 0..F-3; col wraps to 0 and row increments when col==F-3.
//   When row==F-3 and col==F-3, window accepted -> both wrap to 0 (frame end).
//  Decimation: window enters the MAC only if col%STRIDE==0 and row%STRIDE==0; others are counted but dropped.
//   Outputs per frame N=((F-3)/STRIDE+1)^2 (F=28,S=2 -> 169; F=28,S=1 -> 676).
//  i_frame_start: latches i_weight/i_bias into internal registers, zeroes col/row; in-flight pipeline entries still
//   drain with the weights they were computed with. i_frame_start and i_pixel_data_valid in the same cycle:
//   frame start applies first, the window is accepted as (0,0) using the newly latched weights.
//  Pipeline (fixed latency 3 cycles from accepted window to o_conv_valid, no backpressure, one window per cycle):
//   S1: 9 signed products per channel, each 2B bits, registered.
//   S2: sum of 9 products + (sign-extended bias <<< FRAC); accumulator ACC_W=2B+5 bits, registered; no overflow possible.
//   S3: acc >>> FRAC (arithmetic, floor); if relu flag and result<0 -> 0; saturate to [-2^(B-1), 2^(B-1)-1]; registered.
//  o_conv_valid high exactly 3 cycles after a decimation-passing valid window; o_conv_data holds last value otherwise.
//  o_frame_done: asserted in the same cycle as o_conv_valid for the window at (row,col) = last decimated position.
//  Non-valid cycles: counters hold, no stage valid generated; gaps between windows do not change results.
//  Reset mid-frame: all in-flight results discarded, no o_conv_valid/o_frame_done after reset deasserts until new windows.
//  Windows arriving with no prior i_frame_start after reset use zero weights/bias (output 0s, valid still produced).
// STRUCTURE
//  Package conv_pkg: ACC_W function/localparam, sat_b() saturation function, window/weight slice index helpers.
//  Sub-module conv3x3_mac (one channel, S1-S3, relu/sat) instantiated OCH times via generate;
//   top holds counters, decimation, weight/bias latch, valid/frame_done shift registers.
// TESTING
//  T1 F=6,S=2,OCH=2: all pixels 1, weights 1<<FRAC(=16), bias 0, 16 windows -> 4 outputs of 9, frame_done on 4th.
//  T2 F=6,S=1: same stimulus -> 16 outputs, latency exactly 3 cycles each, frame_done on 16th, counts wrap for frame 2.
//  T3 sat/relu: pixels 127, weights 127, bias 0 -> +127; weights -128, relu_en=0 -> -128; relu_en=1 -> 0.
//  T4 bias/floor: pixels 0, bias -1, FRAC=4 -> -1; bias 3 -> 3; sum 8 with bias 0 -> 8>>>4 = 0; sum -8 -> -1.
//  T5 gaps + frame_start collision: random valid gaps, new weights on frame_start coincident with first window ->
//   outputs match golden model, in-flight outputs of prior frame use old weights.
//  T6 async reset mid-frame after 5 windows: outputs 0 immediately, no valid for in-flight windows, next frame correct.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared helpers for the strided 3x3 convolution layer: accumulator sizing,
// output saturation and window/weight slice offsets.
package conv_pkg;

    function automatic int acc_w(input int b);
        return 2 * b + 5;
    endfunction

    // Clamp a wide signed value into the signed range of a b-bit result.
    function automatic logic signed [63:0] sat_b(input logic signed [63:0] v, input int b);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (b - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int pix_idx(input int r, input int c, input int b);
        return (r * 3 + c) * b;
    endfunction

    function automatic int wt_idx(input int k, input int r, input int c, input int b);
        return (k * 9 + r * 3 + c) * b;
    endfunction

endpackage

// File: rtl/conv3x3_mac.sv
// One output channel of the 3x3 convolution: products, biased accumulation,
// then shift/ReLU/saturate, one register stage each.
module conv3x3_mac
    import conv_pkg::*;
#(
    parameter int B    = 8,
    parameter int FRAC = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_v0,
    input  logic           i_v1,
    input  logic           i_v2,
    input  logic           i_relu,
    input  logic [9*B-1:0] i_pix,
    input  logic [9*B-1:0] i_wt,
    input  logic [B-1:0]   i_bias,
    output logic [B-1:0]   o_data
);
    localparam int ACC_W = acc_w(B);
    localparam int PW    = 2 * B;

    logic signed [PW-1:0]    prod_q [9];
    logic signed [PW-1:0]    prod_d [9];
    logic signed [B-1:0]     bias_q;
    logic signed [ACC_W-1:0] acc_q, acc_d, shr;
    logic signed [63:0]      sat_in;
    logic        [B-1:0]     data_q, data_d;

    always_comb begin
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                prod_d[r*3+c] = PW'($signed(i_pix[pix_idx(r, c, B) +: B]))
                              * PW'($signed(i_wt[pix_idx(r, c, B) +: B]));
            end
        end
    end

    // Bias travels alongside the products so a frame_start mid-stream cannot skew S2.
    always_comb begin
        acc_d = ACC_W'(bias_q) <<< FRAC;
        for (int unsigned i = 0; i < 9; i++) begin
            acc_d = acc_d + ACC_W'(prod_q[i]);
        end
    end

    always_comb begin
        shr    = acc_q >>> FRAC;
        sat_in = 64'(shr);
        if (i_relu && shr < 0) sat_in = '0;
        data_d = B'(sat_b(sat_in, B));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prod_q <= '{default: '0};
            bias_q <= '0;
            acc_q  <= '0;
            data_q <= '0;
        end else begin
            if (i_v0) begin
                prod_q <= prod_d;
                bias_q <= i_bias;
            end
            if (i_v1) acc_q <= acc_d;
            if (i_v2) data_q <= data_d;
        end
    end

    assign o_data = data_q;

endmodule

// File: rtl/conv3x3_layer_strided.sv
// Multi-channel strided 3x3 convolution layer: window position tracking,
// 2-D decimation, weight/bias latch and the fixed 3-cycle valid/frame_done pipe.
module conv3x3_layer_strided
    import conv_pkg::*;
#(
    parameter int F      = 28,
    parameter int B      = 8,
    parameter int OCH    = 16,
    parameter int STRIDE = 2,
    parameter int FRAC   = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_frame_start,
    input  logic [9*B-1:0]     i_pixel_data,
    input  logic               i_pixel_data_valid,
    input  logic [OCH*9*B-1:0] i_weight,
    input  logic [OCH*B-1:0]   i_bias,
    input  logic               i_relu_en,
    output logic [OCH*B-1:0]   o_conv_data,
    output logic               o_conv_valid,
    output logic               o_frame_done
);
    localparam int CW = $clog2(F);
    localparam logic [CW-1:0] LAST     = CW'(F - 3);
    localparam logic [CW-1:0] LAST_DEC = CW'(((F - 3) / STRIDE) * STRIDE);

    logic [CW-1:0]      col_q, row_q, col_d, row_d, cur_col, cur_row;
    logic [OCH*9*B-1:0] w_q, w_eff;
    logic [OCH*B-1:0]   b_q, b_eff;
    logic               take, last;
    logic               v1_q, v2_q, valid_q;
    logic               done1_q, done2_q, done_q;
    logic               relu1_q, relu2_q;

    // A frame_start coinciding with a window acts first: that window is (0,0) with the new weights.
    always_comb begin
        cur_col = i_frame_start ? '0 : col_q;
        cur_row = i_frame_start ? '0 : row_q;
        w_eff   = i_frame_start ? i_weight : w_q;
        b_eff   = i_frame_start ? i_bias : b_q;
        take    = i_pixel_data_valid
                  && ((32'(cur_col) % STRIDE) == 0)
                  && ((32'(cur_row) % STRIDE) == 0);
        last    = (cur_col == LAST_DEC) && (cur_row == LAST_DEC);
        col_d   = cur_col;
        row_d   = cur_row;
        if (i_pixel_data_valid) begin
            if (cur_col == LAST) begin
                col_d = '0;
                row_d = (cur_row == LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            col_q   <= '0;
            row_q   <= '0;
            w_q     <= '0;
            b_q     <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            valid_q <= 1'b0;
            done1_q <= 1'b0;
            done2_q <= 1'b0;
            done_q  <= 1'b0;
            relu1_q <= 1'b0;
            relu2_q <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (i_frame_start) begin
                w_q <= i_weight;
                b_q <= i_bias;
            end
            v1_q    <= take;
            v2_q    <= v1_q;
            valid_q <= v2_q;
            done1_q <= take && last;
            done2_q <= done1_q;
            done_q  <= done2_q;
            relu1_q <= i_relu_en;
            relu2_q <= relu1_q;
        end
    end

    for (genvar k = 0; k < OCH; k++) begin : g_ch
        conv3x3_mac #(
            .B    (B),
            .FRAC (FRAC)
        ) u_mac (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_v0   (take),
            .i_v1   (v1_q),
            .i_v2   (v2_q),
            .i_relu (relu2_q),
            .i_pix  (i_pixel_data),
            .i_wt   (w_eff[wt_idx(k, 0, 0, B) +: 9*B]),
            .i_bias (b_eff[k*B +: B]),
            .o_data (o_conv_data[k*B +: B])
        );
    end

    assign o_conv_valid = valid_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_conv3x3_layer_strided.sv
// Bench for conv3x3_layer_strided: two instances (stride 2 and stride 1, F=6)
// against a per-window arithmetic reference with a cycle-indexed expectation table.
module tb_conv3x3_layer_strided;
    localparam int F    = 6;
    localparam int B    = 8;
    localparam int OCH  = 2;
    localparam int FRAC = 4;
    localparam int NS   = 4096;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               fs = 1'b0, pv = 1'b0, relu = 1'b0;
    logic [9*B-1:0]     pix_bus = '0;
    logic [OCH*9*B-1:0] w_bus = '0;
    logic [OCH*B-1:0]   b_bus = '0;
    logic [OCH*B-1:0]   data_s2, data_s1;
    logic               valid_s2, valid_s1, done_s2, done_s1;

    always #5 clk = ~clk;

    conv3x3_layer_strided #(.F(F), .B(B), .OCH(OCH), .STRIDE(2), .FRAC(FRAC)) u_dut_s2 (
        .i_clk(clk), .i_rst(rst), .i_frame_start(fs), .i_pixel_data(pix_bus),
        .i_pixel_data_valid(pv), .i_weight(w_bus), .i_bias(b_bus), .i_relu_en(relu),
        .o_conv_data(data_s2), .o_conv_valid(valid_s2), .o_frame_done(done_s2));

    conv3x3_layer_strided #(.F(F), .B(B), .OCH(OCH), .STRIDE(1), .FRAC(FRAC)) u_dut_s1 (
        .i_clk(clk), .i_rst(rst), .i_frame_start(fs), .i_pixel_data(pix_bus),
        .i_pixel_data_valid(pv), .i_weight(w_bus), .i_bias(b_bus), .i_relu_en(relu),
        .o_conv_data(data_s1), .o_conv_valid(valid_s1), .o_frame_done(done_s1));

    int checks = 0, failures = 0, cyc = 0;
    int STR[2] = '{2, 1};
    int pix[9];
    int w_in[OCH][9], b_in[OCH];
    int w_l[OCH][9], b_l[OCH];
    int mc[2], mr[2], nv[2], nd[2];
    bit ev[2][NS];
    bit ed[2][NS];
    logic [OCH*B-1:0] edat[2][NS];
    logic [OCH*B-1:0] held[2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [B-1:0] ref_out(input int ch, input bit r);
        int s;
        s = b_l[ch] * (2 ** FRAC);
        for (int t = 0; t < 9; t++) s += pix[t] * w_l[ch][t];
        s = s >>> FRAC;
        if (r && s < 0) s = 0;
        if (s > 2 ** (B - 1) - 1) s = 2 ** (B - 1) - 1;
        if (s < -(2 ** (B - 1))) s = -(2 ** (B - 1));
        return B'(s);
    endfunction

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            logic v, dn;
            logic [OCH*B-1:0] dat;
            v   = (d == 0) ? valid_s2 : valid_s1;
            dn  = (d == 0) ? done_s2 : done_s1;
            dat = (d == 0) ? data_s2 : data_s1;
            if (ev[d][cyc]) held[d] = edat[d][cyc];
            check_eq($sformatf("valid_s%0d@%0d", STR[d], cyc), 64'(v), 64'(ev[d][cyc]));
            check_eq($sformatf("done_s%0d@%0d", STR[d], cyc), 64'(dn), 64'(ed[d][cyc]));
            check_eq($sformatf("data_s%0d@%0d", STR[d], cyc), 64'(dat), 64'(held[d]));
            if (v === 1'b1) nv[d]++;
            if (dn === 1'b1) nd[d]++;
        end
    endtask

    task automatic step(input bit f, input bit v, input bit r);
        @(negedge clk);
        check_outputs();
        rst  = 1'b0;
        fs   = f;
        pv   = v;
        relu = r;
        for (int t = 0; t < 9; t++) pix_bus[t*B +: B] = B'(pix[t]);
        for (int k = 0; k < OCH; k++) begin
            b_bus[k*B +: B] = B'(b_in[k]);
            for (int t = 0; t < 9; t++) w_bus[(k*9+t)*B +: B] = B'(w_in[k][t]);
        end
        if (f) begin
            w_l = w_in;
            b_l = b_in;
            mc  = '{0, 0};
            mr  = '{0, 0};
        end
        if (v) begin
            for (int d = 0; d < 2; d++) begin
                int ld;
                ld = ((F - 3) / STR[d]) * STR[d];
                if ((mc[d] % STR[d]) == 0 && (mr[d] % STR[d]) == 0 && cyc + 3 < NS) begin
                    ev[d][cyc+3] = 1'b1;
                    ed[d][cyc+3] = (mc[d] == ld) && (mr[d] == ld);
                    for (int k = 0; k < OCH; k++) edat[d][cyc+3][k*B +: B] = ref_out(k, r);
                end
                if (mc[d] == F - 3) begin
                    mc[d] = 0;
                    mr[d] = (mr[d] == F - 3) ? 0 : mr[d] + 1;
                end else begin
                    mc[d]++;
                end
            end
        end
        cyc++;
    endtask

    task automatic do_reset(input bit chk);
        @(negedge clk);
        if (chk) check_outputs();
        rst = 1'b1;
        fs  = 1'b0;
        pv  = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int i = cyc + 1; i < NS; i++) begin
                ev[d][i] = 1'b0;
                ed[d][i] = 1'b0;
            end
            held[d] = '0;
            mc[d]   = 0;
            mr[d]   = 0;
        end
        w_l = '{default: '{default: 0}};
        b_l = '{default: 0};
        check_eq("rst_valid", 64'({valid_s2, valid_s1}), 64'd0);
        check_eq("rst_done", 64'({done_s2, done_s1}), 64'd0);
        check_eq("rst_data", 64'({data_s2, data_s1}), 64'd0);
        cyc++;
    endtask

    task automatic set_uniform(input int p, input int w, input int b);
        for (int t = 0; t < 9; t++) pix[t] = p;
        for (int k = 0; k < OCH; k++) begin
            b_in[k] = b;
            for (int t = 0; t < 9; t++) w_in[k][t] = w;
        end
    endtask

    task automatic run_one(input string tag, input bit r, input logic [B-1:0] exp);
        step(1'b1, 1'b1, r);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        check_eq({tag, "_s2"}, 64'(data_s2[B-1:0]), 64'(exp));
        check_eq({tag, "_s1"}, 64'(data_s1[2*B-1:B]), 64'(exp));
    endtask

    task automatic frame_counts(input string tag, input int e2, input int e1);
        check_eq({tag, "_nv_s2"}, 64'(nv[0]), 64'(e2));
        check_eq({tag, "_nd_s2"}, 64'(nd[0]), 64'd1);
        check_eq({tag, "_nv_s1"}, 64'(nv[1]), 64'(e1));
        check_eq({tag, "_nd_s1"}, 64'(nd[1]), 64'd1);
    endtask

    task automatic rand_weights();
        for (int k = 0; k < OCH; k++) begin
            b_in[k] = int'($urandom_range(0, 255)) - 128;
            for (int t = 0; t < 9; t++)
                w_in[k][t] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 255)) - 128
                                                         : int'($urandom_range(0, 8)) - 4;
        end
    endtask

    task automatic rand_pixels();
        for (int t = 0; t < 9; t++) pix[t] = int'($urandom_range(0, 255)) - 128;
    endtask

    initial begin
        set_uniform(0, 0, 0);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NS; i++) begin
                ev[d][i] = 1'b0;
                ed[d][i] = 1'b0;
                edat[d][i] = '0;
            end
            held[d] = '0;
        end
        do_reset(1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0);

        // Windows with no frame_start since reset: zero weights, valid still produced
        rand_pixels();
        repeat (2) step(1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0);

        // Unit pixels, unit weights: 9 per output; stride-2 gives 4, stride-1 gives 16
        set_uniform(1, 16, 0);
        nv = '{0, 0};
        nd = '{0, 0};
        step(1'b1, 1'b1, 1'b0);
        repeat (15) step(1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        check_eq("t1_value", 64'(data_s2), 64'h0909);
        frame_counts("t1", 4, 16);

        // Second frame without frame_start: counters must have wrapped
        nv = '{0, 0};
        nd = '{0, 0};
        repeat (16) step(1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        frame_counts("t2", 4, 16);

        // Saturation and ReLU
        set_uniform(127, 127, 0);
        run_one("t3_pos_sat", 1'b0, 8'h7f);
        set_uniform(127, -128, 0);
        run_one("t3_neg_sat", 1'b0, 8'h80);
        run_one("t3_relu", 1'b1, 8'h00);

        // Bias alignment and floor shift
        set_uniform(0, 0, -1);
        run_one("t4_bias_m1", 1'b0, 8'hff);
        set_uniform(0, 0, 3);
        run_one("t4_bias_3", 1'b0, 8'h03);
        set_uniform(0, 0, 0);
        pix[4] = 8;
        w_in[0][4] = 1;
        w_in[1][4] = 1;
        run_one("t4_floor_p8", 1'b0, 8'h00);
        pix[4] = -8;
        run_one("t4_floor_m8", 1'b0, 8'hff);

        // Random gaps, frame_start collisions with in-flight windows
        rand_weights();
        rand_pixels();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 400; i++) begin
            bit f, v, r;
            f = ($urandom_range(0, 30) == 0);
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 1) == 1;
            if (f) rand_weights();
            rand_pixels();
            step(f, v, r);
        end
        repeat (4) step(1'b0, 1'b0, 1'b0);

        // Reset with windows in flight, then a clean frame
        rand_weights();
        rand_pixels();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rand_pixels();
            step(1'b0, 1'b1, 1'b0);
        end
        do_reset(1'b1);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        rand_weights();
        nv = '{0, 0};
        nd = '{0, 0};
        for (int i = 0; i < 16; i++) begin
            rand_pixels();
            step(i == 0, 1'b1, $urandom_range(0, 1) == 1);
        end
        repeat (4) step(1'b0, 1'b0, 1'b0);
        frame_counts("t6", 4, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
